// File: rtl/fifo_status_arbiter.sv
// Multi-channel FIFO level watcher with a round-robin request arbiter for a shared AXI master.
// Optional done watchdog is compiled in when FIFO_STATUS_TIMEOUT_EN is defined.
module fifo_status_arbiter #(
  parameter int unsigned CH        = 4,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned LSIZE     = 9,
  parameter int unsigned THRESHOLD = 200,
  parameter int unsigned FULL_LEN  = 256,
  parameter int unsigned BURST_LEN = 100,
  parameter int unsigned RST_WAIT  = 31,
  parameter string       MODE      = "ONCE",
  parameter string       WR_RD     = "READ",
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic                                      clock,
  input  logic                                      rst,
  input  logic [CH-1:0]                             enable,
  input  logic [CH*CNT_W-1:0]                       count,
  input  logic [CH-1:0]                             fsync,
  input  logic [CH-1:0]                             tail_status,
  input  logic [CH*LSIZE-1:0]                       tail_len,
  output logic                                      req_valid,
  output logic                                      req_tail,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0]    req_ch,
  output logic [LSIZE-1:0]                          req_len,
  input  logic                                      resp,
  input  logic                                      done,
  output logic [CH-1:0]                             burst_done,
  output logic [CH-1:0]                             tail_done,
  output logic                                      busy,
  output logic                                      timeout_err
);

  localparam int unsigned CH_W    = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned CMP_W   = (CNT_W > 32) ? CNT_W : 32;
  localparam int unsigned WC_W    = (RST_WAIT > 0) ? $clog2(RST_WAIT + 1) : 1;
  localparam bit          IS_READ = (WR_RD == "READ");
  localparam bit          IS_ONCE = (MODE == "ONCE");

  typedef enum logic [1:0] {CS_WAIT_RST, CS_READY, CS_TAIL_HOLD} ch_state_t;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_DONE, S_FSH, S_DRAIN} state_t;

  state_t           r_state, w_state_nxt;
  ch_state_t        r_ch_st [CH];
  ch_state_t        w_ch_st_nxt [CH];
  logic [WC_W-1:0]  r_wcnt [CH];
  logic [WC_W-1:0]  w_wcnt_nxt [CH];
  logic [LSIZE-1:0] w_tlen [CH];
  logic [CH-1:0]    r_trig, w_trig, w_elig, w_to_wait, w_to_hold;
  logic [CH_W-1:0]  r_rr, w_rr_nxt, w_gnt_ch, w_idx;
  logic             w_gnt_vld, w_tmo;
  logic             r_req_valid, w_req_valid_nxt, r_req_tail, w_req_tail_nxt, r_busy;
  logic [CH_W-1:0]  r_req_ch, w_req_ch_nxt;
  logic [LSIZE-1:0] r_req_len, w_req_len_nxt;
  logic [CH-1:0]    r_burst_done, w_burst_done_nxt, r_tail_done, w_tail_done_nxt;

  // Trigger compare, eligibility and per-channel tail length unpacking
  always_comb begin
    w_trig = '0;
    w_elig = '0;
    for (int i = 0; i < CH; i++) begin
      if (IS_READ)
        w_trig[i] = enable[i] && (CMP_W'(FULL_LEN - THRESHOLD) > CMP_W'(count[i*CNT_W +: CNT_W]));
      else
        w_trig[i] = enable[i] && (CMP_W'(count[i*CNT_W +: CNT_W]) > CMP_W'(THRESHOLD));
      w_elig[i] = r_trig[i] && (r_ch_st[i] == CS_READY);
      w_tlen[i] = tail_len[i*LSIZE +: LSIZE];
    end
  end

  // Round-robin pick: first eligible channel at or after the pointer
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    w_idx     = '0;
    for (int k = 0; k < CH; k++) begin
      w_idx = CH_W'((32'(r_rr) + 32'(k)) % CH);
      if (!w_gnt_vld && w_elig[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_ch  = w_idx;
      end
    end
  end

  // Per-channel reset-wait / ready / tail-hold next state
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_ch_st_nxt[i] = r_ch_st[i];
      w_wcnt_nxt[i]  = r_wcnt[i];
      case (r_ch_st[i])
        CS_WAIT_RST: begin
          if (fsync[i])                            w_wcnt_nxt[i]  = '0;
          else if (r_wcnt[i] >= WC_W'(RST_WAIT))   w_ch_st_nxt[i] = CS_READY;
          else                                     w_wcnt_nxt[i]  = r_wcnt[i] + WC_W'(1);
        end
        CS_READY: begin
          if (fsync[i] || w_to_wait[i]) begin
            w_ch_st_nxt[i] = CS_WAIT_RST;
            w_wcnt_nxt[i]  = '0;
          end else if (w_to_hold[i]) begin
            w_ch_st_nxt[i] = CS_TAIL_HOLD;
          end
        end
        CS_TAIL_HOLD: begin
          if (fsync[i]) begin
            w_ch_st_nxt[i] = CS_WAIT_RST;
            w_wcnt_nxt[i]  = '0;
          end
        end
        default: begin
          w_ch_st_nxt[i] = CS_WAIT_RST;
          w_wcnt_nxt[i]  = '0;
        end
      endcase
    end
  end

  // Central request FSM next state and registered-output next values
  always_comb begin
    w_state_nxt      = r_state;
    w_req_valid_nxt  = r_req_valid;
    w_req_tail_nxt   = r_req_tail;
    w_req_ch_nxt     = r_req_ch;
    w_req_len_nxt    = r_req_len;
    w_burst_done_nxt = '0;
    w_tail_done_nxt  = '0;
    w_rr_nxt         = r_rr;
    w_to_wait        = '0;
    w_to_hold        = '0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_state_nxt     = S_REQ;
          w_req_valid_nxt = 1'b1;
          w_req_ch_nxt    = w_gnt_ch;
          w_req_tail_nxt  = tail_status[w_gnt_ch];
          w_req_len_nxt   = tail_status[w_gnt_ch] ? w_tlen[w_gnt_ch] : LSIZE'(BURST_LEN);
        end
      end
      S_REQ: begin
        if (w_tmo || fsync[r_req_ch]) begin
          w_req_valid_nxt     = 1'b0;
          w_to_wait[r_req_ch] = 1'b1;
          w_state_nxt         = (!w_tmo && resp) ? S_DRAIN : S_IDLE;
        end else if (resp) begin
          w_req_valid_nxt = 1'b0;
          w_state_nxt     = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (w_tmo || fsync[r_req_ch]) begin
          w_to_wait[r_req_ch] = 1'b1;
          w_state_nxt         = (w_tmo || done) ? S_IDLE : S_DRAIN;
        end else if (done) begin
          w_state_nxt                = S_FSH;
          w_burst_done_nxt[r_req_ch] = !r_req_tail;
          w_tail_done_nxt[r_req_ch]  = r_req_tail;
        end
      end
      S_FSH: begin
        w_rr_nxt    = CH_W'((32'(r_req_ch) + 32'd1) % CH);
        w_state_nxt = S_IDLE;
        if (IS_ONCE && r_req_tail) w_to_hold[r_req_ch] = 1'b1;
      end
      S_DRAIN: begin
        if (done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_trig       <= '0;
      r_rr         <= '0;
      r_req_valid  <= 1'b0;
      r_req_tail   <= 1'b0;
      r_req_ch     <= '0;
      r_req_len    <= '0;
      r_burst_done <= '0;
      r_tail_done  <= '0;
      r_busy       <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        r_ch_st[i] <= CS_WAIT_RST;
        r_wcnt[i]  <= '0;
      end
    end else begin
      r_state      <= w_state_nxt;
      r_trig       <= w_trig;
      r_rr         <= w_rr_nxt;
      r_req_valid  <= w_req_valid_nxt;
      r_req_tail   <= w_req_tail_nxt;
      r_req_ch     <= w_req_ch_nxt;
      r_req_len    <= w_req_len_nxt;
      r_burst_done <= w_burst_done_nxt;
      r_tail_done  <= w_tail_done_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      for (int i = 0; i < CH; i++) begin
        r_ch_st[i] <= w_ch_st_nxt[i];
        r_wcnt[i]  <= w_wcnt_nxt[i];
      end
    end
  end

`ifdef FIFO_STATUS_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_tcnt;
  logic            r_timeout_err;

  // Watchdog restarts on every state change and only runs while a request is outstanding
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_tcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_tmo;
      if (w_state_nxt != r_state)
        r_tcnt <= '0;
      else if (r_state == S_REQ || r_state == S_WAIT_DONE)
        r_tcnt <= r_tcnt + TO_W'(1);
    end
  end

  assign w_tmo       = (r_state == S_REQ || r_state == S_WAIT_DONE) && (r_tcnt == TO_W'(TIMEOUT - 1));
  assign timeout_err = r_timeout_err;
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign req_valid  = r_req_valid;
  assign req_tail   = r_req_tail;
  assign req_ch     = r_req_ch;
  assign req_len    = r_req_len;
  assign burst_done = r_burst_done;
  assign tail_done  = r_tail_done;
  assign busy       = r_busy;

endmodule

// File: doc/fifo_status_arbiter.md
Name: fifo_status_arbiter

Overview:
- Multi-channel successor to the single-channel FIFO status controller.
- Watches CH independent FIFO fill levels (read-side or write-side) and decides when each channel needs a burst or a line/frame tail transfer.
- Arbitrates round-robin among eligible channels and issues one request at a time to a shared AXI master, tagged with the channel id.
- Sits between the per-channel stream FIFOs and the shared AXI burst engine in the VDMA.

Parameters:
- CH, 4, number of channels (1..16)
- CNT_W, 10, width of each channel's FIFO count
- LSIZE, 9, width of burst/tail length
- THRESHOLD, 200, empty (READ) or fill (WRITE) threshold, same for all channels
- FULL_LEN, 256, FIFO depth used in the READ trigger
- BURST_LEN, 100, length of a normal burst
- RST_WAIT, 31, consecutive fsync-low cycles required before a channel leaves WAIT_RST
- MODE, "ONCE", "ONCE" holds a channel after tail until fsync; "LINE" re-arms immediately
- WR_RD, "READ", "READ" or "WRITE" trigger polarity
- TIMEOUT, 4096, done watchdog in cycles (optional feature only)

Ports:
- clock  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  CH  per-channel enable
- count  in  CH*CNT_W  per-channel FIFO count; channel i in bits [i*CNT_W +: CNT_W]
- fsync  in  CH  per-channel frame sync, level
- tail_status  in  CH  next transfer of channel i is a tail
- tail_len  in  CH*LSIZE  per-channel tail length
- req_valid  out  1  request to AXI master
- req_tail  out  1  current request is a tail
- req_ch  out  $clog2(CH) (min 1)  channel of current request
- req_len  out  LSIZE  length of current request
- resp  in  1  request accepted, 1-cycle pulse
- done  in  1  transfer complete, 1-cycle pulse
- burst_done  out  CH  1-cycle per-channel burst completion
- tail_done  out  CH  1-cycle per-channel tail completion
- busy  out  1  central FSM not IDLE
- timeout_err  out  1  watchdog pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset: all outputs 0, every channel in WAIT_RST, wait counters 0, RR pointer 0, central FSM IDLE.
- Trigger, registered, 1-cycle latency from count:
  - READ: trig[i] = enable[i] && (FULL_LEN-THRESHOLD > count[i]).
  - WRITE: trig[i] = enable[i] && (count[i] > THRESHOLD).
  - Compare unsigned at width max(CNT_W, 32).
- Per-channel state:
  - WAIT_RST: counter increments on fsync=0, clears on fsync=1, saturates. Go to READY when counter >= RST_WAIT.
  - READY: eligible when trig[i]=1 and the channel is not active. fsync=1 -> WAIT_RST.
  - TAIL_HOLD (ONCE only): not eligible. fsync=1 -> WAIT_RST.
- Central FSM:
  - IDLE: if any eligible channel, grant the first one at or after the RR pointer (wrapping), latch req_ch, req_tail=tail_status, req_len=tail_len slice or BURST_LEN. -> REQ. req_valid=1 from the next cycle.
  - REQ: hold req_valid/req_ch/req_tail/req_len stable. resp -> WAIT_DONE with req_valid=0 the next cycle.
  - WAIT_DONE: done -> FSH.
  - FSH (1 cycle): pulse burst_done[req_ch] or tail_done[req_ch]. RR pointer = req_ch+1 mod CH. Tail in ONCE -> channel to TAIL_HOLD. -> IDLE.
  - DRAIN: wait for done, no done pulse. -> IDLE.
- Abort on fsync[req_ch]=1:
  - In REQ: drop req_valid next cycle, -> IDLE, channel -> WAIT_RST.
  - In WAIT_DONE: -> DRAIN, channel -> WAIT_RST.
  - resp and fsync in the same REQ cycle: abort wins, -> DRAIN.
- done arriving in the same cycle as the fsync abort: treat as completion drained. No pulse; -> IDLE.
- fsync on non-active channels never disturbs the central FSM.
- req_len holds its last value while IDLE.
- Minimum spacing: one request per 4 cycles (IDLE, REQ, WAIT_DONE, FSH).

Optional Feature:
- Macro: FIFO_STATUS_TIMEOUT_EN.
- When defined: a counter runs in REQ and WAIT_DONE and clears on state entry. On reaching TIMEOUT:
  - pulse timeout_err for 1 cycle;
  - drop req_valid;
  - send the active channel to WAIT_RST and the central FSM to IDLE (no DRAIN).
- When undefined: no counter, timeout_err tied to 0, and the FSM waits indefinitely.

Test Plan:
- Reset, all fsync=0 for 31 cycles, count0=10 (READ, enable0=1) -> req_valid at first eligible grant, req_ch=0, req_len=100, req_tail=0. resp then done -> burst_done[0] pulses exactly 1 cycle.
- Channels 0, 1, 3 triggered continuously -> grant order 0,1,3,0,1,3. Channel 2 never granted while count2=250.
- tail_status1=1, tail_len1=37, MODE ONCE -> req_tail=1, req_len=37, tail_done[1] pulse. Channel 1 then not granted until fsync1 pulse plus 31 low cycles.
- fsync2 asserted in WAIT_DONE for ch2 -> no burst_done[2]. busy stays 1 until done (DRAIN), then other channels granted.
- WRITE mode, count0=201, THRESHOLD=200 -> trigger. count0=200 -> no request.
- With FIFO_STATUS_TIMEOUT_EN, TIMEOUT=16, withhold resp -> timeout_err pulse 16 cycles after REQ entry, req_valid=0 next cycle, FSM IDLE.
